// File: rtl/pipe_stage.sv
// Two-entry skid stage: one cycle accept-to-valid when empty, strict FIFO order, flush squashes and counts.
// Backpressure: in_ready drops when both entries are held or on stall/flush; out_ready low holds data in place.
module pipe_stage #(
  parameter int                DATA_W = 96,
  parameter logic [DATA_W-1:0] BUBBLE = {DATA_W{1'b0}},
  parameter int                CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  input  logic              stall,
  input  logic              flush,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  localparam logic [CNT_W+1:0] CNT_MAX = {2'b00, {CNT_W{1'b1}}};

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic [DATA_W-1:0] main_dat;
  logic [DATA_W-1:0] main_nxt;
  logic [DATA_W-1:0] skid_dat;
  logic [DATA_W-1:0] skid_nxt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic [CNT_W+1:0]  cnt_sum;
  logic              main_vld;
  logic              accept;
  logic              emit;

  assign main_vld  = (state != ST_EMPTY);
  assign in_ready  = (state != ST_FULL) && !stall && !flush;
  assign out_valid = main_vld && !stall && !flush;
  assign out_data  = main_vld ? main_dat : BUBBLE;
  assign accept    = in_valid && in_ready;
  assign emit      = out_valid && out_ready;

  always_comb begin
    occupancy = 2'd0;
    case (state)
      ST_ONE:  occupancy = 2'd1;
      ST_FULL: occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

  // Extra headroom bits let the saturation test see the overflow before truncation.
  assign cnt_sum = {2'b00, flush_cnt} + {{CNT_W{1'b0}}, occupancy};

  always_comb begin
    state_nxt = state;
    main_nxt  = main_dat;
    skid_nxt  = skid_dat;
    cnt_nxt   = flush_cnt;
    if (flush) begin
      state_nxt = ST_EMPTY;
      main_nxt  = BUBBLE;
      skid_nxt  = BUBBLE;
      cnt_nxt   = (cnt_sum > CNT_MAX) ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
    end else if (!stall) begin
      case (state)
        ST_EMPTY: begin
          if (accept) begin
            state_nxt = ST_ONE;
            main_nxt  = in_data;
          end
        end
        ST_ONE: begin
          if (accept && emit) begin
            main_nxt = in_data;
          end else if (accept) begin
            state_nxt = ST_FULL;
            skid_nxt  = in_data;
          end else if (emit) begin
            state_nxt = ST_EMPTY;
            main_nxt  = BUBBLE;
          end
        end
        ST_FULL: begin
          if (emit) begin
            state_nxt = ST_ONE;
            main_nxt  = skid_dat;
            skid_nxt  = BUBBLE;
          end
        end
        default: begin
          state_nxt = ST_EMPTY;
          main_nxt  = BUBBLE;
          skid_nxt  = BUBBLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_EMPTY;
      main_dat  <= BUBBLE;
      skid_dat  <= BUBBLE;
      flush_cnt <= {CNT_W{1'b0}};
    end else begin
      state     <= state_nxt;
      main_dat  <= main_nxt;
      skid_dat  <= skid_nxt;
      flush_cnt <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_pipe_stage.sv
// Bench for pipe_stage: queue-level reference model checked every falling edge, plus directed literal checks.
module tb_pipe_stage;

  localparam int          DW  = 96;
  localparam int          CW  = 2;
  localparam logic [95:0] BUB = 96'hB0B;
  localparam int          CNT_SAT = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready;
  logic          stall;
  logic          flush;
  logic [1:0]    occupancy;
  logic [CW-1:0] flush_cnt;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  logic [DW-1:0] mq[$];
  int            m_cnt;
  bit            m_acc;
  bit            m_em;

  pipe_stage #(.DATA_W(DW), .BUBBLE(BUB), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .stall(stall), .flush(flush),
    .occupancy(occupancy), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a bounded queue of held payloads plus a saturating discard counter.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mq.delete();
      m_cnt = 0;
    end else if (flush) begin
      m_cnt = m_cnt + mq.size();
      if (m_cnt > CNT_SAT) m_cnt = CNT_SAT;
      mq.delete();
    end else if (!stall) begin
      m_acc = in_valid && (mq.size() < 2);
      m_em  = out_ready && (mq.size() > 0);
      if (m_em) void'(mq.pop_front());
      if (m_acc) mq.push_back(in_data);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("cmp.occupancy", 96'(occupancy), 96'(mq.size()));
      check("cmp.in_ready", 96'(in_ready), 96'((mq.size() < 2) && !stall && !flush));
      check("cmp.out_valid", 96'(out_valid), 96'((mq.size() > 0) && !stall && !flush));
      check("cmp.out_data", out_data, (mq.size() > 0) ? mq[0] : BUB);
      check("cmp.flush_cnt", 96'(flush_cnt), 96'(m_cnt));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_full(input logic [95:0] a, input logic [95:0] b);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = a;
    step();
    in_data   = b;
    step();
    in_valid  = 1'b0;
  endtask

  task automatic flush_full();
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = 96'h33;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
  endtask

  // Mixed-control vectors {in_valid, out_ready, stall, flush}
  logic [3:0] vec [0:19] = '{4'b1100, 4'b1000, 4'b1010, 4'b1100, 4'b0100,
                             4'b1000, 4'b1000, 4'b0110, 4'b0100, 4'b1101,
                             4'b1100, 4'b1100, 4'b1000, 4'b0001, 4'b1000,
                             4'b1011, 4'b0100, 4'b1100, 4'b0100, 4'b0000};

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    stall = 1'b0; flush = 1'b0;
    #1 rst = 1'b0;
    chk_en = 1'b1;
    #1;
    check("rst.out_valid", 96'(out_valid), 96'd0);
    check("rst.occupancy", 96'(occupancy), 96'd0);
    check("rst.out_data", out_data, BUB);
    check("rst.flush_cnt", 96'(flush_cnt), 96'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    check("rst.in_ready_first", 96'(in_ready), 96'd1);

    // Streaming
    out_ready = 1'b1; in_valid = 1'b1; in_data = 96'h13;
    step();
    check("stream.a_valid", 96'(out_valid), 96'd1);
    check("stream.a_data", out_data, 96'h13);
    check("stream.a_occ", 96'(occupancy), 96'd1);
    in_data = 96'h93;
    step();
    check("stream.b_data", out_data, 96'h93);
    check("stream.b_occ", 96'(occupancy), 96'd1);
    in_valid = 1'b0;
    step();
    check("stream.drain_occ", 96'(occupancy), 96'd0);

    // Backpressure then stall while full
    out_ready = 1'b0; in_valid = 1'b1; in_data = 96'hAA;
    step();
    in_data = 96'hBB;
    step();
    check("bp.occ", 96'(occupancy), 96'd2);
    check("bp.in_ready", 96'(in_ready), 96'd0);
    in_data = 96'hCC;
    step();
    check("bp.hold_data", out_data, 96'hAA);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall.out_valid", 96'(out_valid), 96'd0);
      check("stall.in_ready", 96'(in_ready), 96'd0);
      check("stall.occ", 96'(occupancy), 96'd2);
    end
    stall = 1'b0; out_ready = 1'b1;
    #1;
    check("stall.release_valid", 96'(out_valid), 96'd1);
    check("stall.release_data", out_data, 96'hAA);
    step();
    check("bp.second", out_data, 96'hBB);
    step();
    check("bp.third", out_data, 96'hCC);
    in_valid = 1'b0;
    step();
    check("bp.empty", 96'(occupancy), 96'd0);

    // Flush of a full stage with a competing input
    fill_full(96'h11, 96'h22);
    flush = 1'b1; in_valid = 1'b1; in_data = 96'h33;
    #1;
    check("flush.in_ready", 96'(in_ready), 96'd0);
    check("flush.out_valid", 96'(out_valid), 96'd0);
    step();
    flush = 1'b0; in_valid = 1'b0;
    check("flush.occ", 96'(occupancy), 96'd0);
    check("flush.out_data", out_data, BUB);
    check("flush.cnt", 96'(flush_cnt), 96'd2);
    out_ready = 1'b1;
    step();
    check("flush.no_capture", 96'(occupancy), 96'd0);

    // Saturation with a 2-bit counter
    fill_full(96'h44, 96'h55);
    flush_full();
    check("sat.cnt_2nd", 96'(flush_cnt), 96'd3);
    fill_full(96'h66, 96'h77);
    flush_full();
    fill_full(96'h88, 96'h99);
    flush_full();
    check("sat.cnt_4th", 96'(flush_cnt), 96'd3);

    // Asynchronous reset between edges while one entry held
    out_ready = 1'b0; in_valid = 1'b1; in_data = 96'h5A;
    step();
    in_valid = 1'b0;
    check("arst.pre_valid", 96'(out_valid), 96'd1);
    #1 rst = 1'b0;
    #1;
    check("arst.out_valid", 96'(out_valid), 96'd0);
    check("arst.occ", 96'(occupancy), 96'd0);
    check("arst.cnt", 96'(flush_cnt), 96'd0);
    check("arst.out_data", out_data, BUB);
    rst = 1'b1;
    step();
    check("arst.in_ready", 96'(in_ready), 96'd1);

    // Mixed control sequence, checked by the reference each cycle
    for (int i = 0; i < 20; i++) begin
      {in_valid, out_ready, stall, flush} = vec[i];
      in_data = 96'h100 + 96'(i);
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1; stall = 1'b0; flush = 1'b0;
    repeat (3) step();
    check("end.occ", 96'(occupancy), 96'd0);

    @(negedge clk);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
